// File: rtl/rob_mw_if.sv
// Reorder-buffer bus: dispatch, completion, flush, retire and rollback signals.
// The renamer/FU/LSU side uses master; the ROB uses slave.
interface rob_mw_if #(
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int FU_COUNT     = 4,
  parameter int RETIRE_WIDTH = 2
);
  logic                                                inst_valid;
  logic                                                inst_ready;
  logic [63:0]                                         pc;
  logic [MAX_OPERANDS-1:0]                             mapping_inputs_valid;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]               mapping_inputs_prn;
  logic [MAX_OPERANDS-1:0][5:0]                        mapping_inputs_arn;
  logic [INST_ID_BITS-1:0]                             new_inst_id;
  logic [FU_COUNT-1:0]                                 fu_out_inst_valid;
  logic [FU_COUNT-1:0][INST_ID_BITS-1:0]               fu_out_inst_ids;
  logic                                                flush_valid;
  logic [INST_ID_BITS-1:0]                             flush_inst_id;
  logic [RETIRE_WIDTH-1:0]                             retire_valid;
  logic [RETIRE_WIDTH-1:0][INST_ID_BITS-1:0]           retire_inst_id;
  logic [RETIRE_WIDTH-1:0][MAX_OPERANDS-1:0]           freed_prns_valid;
  logic [RETIRE_WIDTH-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] freed_prns;
  logic                                                rollback_valid;
  logic [MAX_OPERANDS-1:0]                             rollback_mapping_valid;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]               rollback_mapping_prn;
  logic [MAX_OPERANDS-1:0][5:0]                        rollback_mapping_arn;
  logic                                                rollback_done;
  logic                                                empty;

  modport master (
    output inst_valid, pc, mapping_inputs_valid, mapping_inputs_prn, mapping_inputs_arn,
           fu_out_inst_valid, fu_out_inst_ids, flush_valid, flush_inst_id,
    input  inst_ready, new_inst_id, retire_valid, retire_inst_id, freed_prns_valid,
           freed_prns, rollback_valid, rollback_mapping_valid, rollback_mapping_prn,
           rollback_mapping_arn, rollback_done, empty
  );

  modport slave (
    input  inst_valid, pc, mapping_inputs_valid, mapping_inputs_prn, mapping_inputs_arn,
           fu_out_inst_valid, fu_out_inst_ids, flush_valid, flush_inst_id,
    output inst_ready, new_inst_id, retire_valid, retire_inst_id, freed_prns_valid,
           freed_prns, rollback_valid, rollback_mapping_valid, rollback_mapping_prn,
           rollback_mapping_arn, rollback_done, empty
  );
endinterface

// File: rtl/rob_mw.sv
// Reorder buffer: circular queue with in-order multi-lane retirement and
// youngest-first replay of squashed mappings after a flush.
//
// state       | meaning
// ST_RUN      | normal dispatch/complete/retire, flushes accepted
// ST_ROLLBACK | replaying one squashed entry per cycle, dispatch blocked
module rob_mw #(
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int FU_COUNT     = 4,
  parameter int RETIRE_WIDTH = 2
) (
  input logic      clk,
  input logic      rst_n,
  rob_mw_if.slave  bus
);
  localparam int DEPTH = 1 << INST_ID_BITS;
  localparam int CW    = INST_ID_BITS + 1;
  localparam int IB    = INST_ID_BITS;

  typedef enum logic {ST_RUN = 1'b0, ST_ROLLBACK = 1'b1} state_t;

  state_t                r_state, w_state_nxt;
  logic [IB-1:0]         r_head, r_tail;
  logic [CW-1:0]         r_count, r_rb_left;
  logic [DEPTH-1:0]      r_committed;

  logic [63:0]                           r_pc        [DEPTH];
  logic [MAX_OPERANDS-1:0]               r_map_valid [DEPTH];
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] r_map_prn   [DEPTH];
  logic [MAX_OPERANDS-1:0][5:0]          r_map_arn   [DEPTH];

  logic [RETIRE_WIDTH-1:0]                                 r_retire_valid;
  logic [RETIRE_WIDTH-1:0][IB-1:0]                         r_retire_inst_id;
  logic [RETIRE_WIDTH-1:0][MAX_OPERANDS-1:0]               r_freed_valid;
  logic [RETIRE_WIDTH-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] r_freed_prns;
  logic                                  r_rb_valid, r_rb_done;
  logic [MAX_OPERANDS-1:0]               r_rb_map_valid;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] r_rb_map_prn;
  logic [MAX_OPERANDS-1:0][5:0]          r_rb_map_arn;

  logic                            w_ready, w_disp, w_rb, w_flush_acc, w_chain;
  logic [CW-1:0]                   w_flush_n, w_pend, w_ret_lim, w_n_ret;
  logic [IB-1:0]                   w_rb_idx;
  logic [RETIRE_WIDTH-1:0]         w_ret_ok;
  logic [RETIRE_WIDTH-1:0][IB-1:0] w_ret_idx;
  logic [FU_COUNT-1:0]             w_fu_occ;

  function automatic logic f_occ(input logic [IB-1:0] id, input logic [IB-1:0] tail,
                                 input logic [CW-1:0] cnt);
    logic [IB-1:0] off;
    off = id - tail;
    return {1'b0, off} < cnt;
  endfunction

  always_comb begin
    w_ready     = (r_state == ST_RUN) && (r_count != CW'(DEPTH)) && !bus.flush_valid;
    w_disp      = bus.inst_valid && w_ready;
    w_rb        = (r_state == ST_ROLLBACK);
    w_rb_idx    = r_head - IB'(1);
    w_flush_acc = (r_state == ST_RUN) && bus.flush_valid &&
                  f_occ(bus.flush_inst_id, r_tail, r_count);
    w_flush_n   = r_count - {1'b0, bus.flush_inst_id - r_tail} - CW'(1);
    for (int f = 0; f < FU_COUNT; f++)
      w_fu_occ[f] = f_occ(bus.fu_out_inst_ids[f], r_tail, r_count);

    // entries awaiting squash must never retire, even if already committed
    if (w_rb)             w_pend = r_rb_left;
    else if (w_flush_acc) w_pend = w_flush_n;
    else                  w_pend = '0;
    w_ret_lim = r_count - w_pend;

    w_ret_ok  = '0;
    w_ret_idx = '0;
    w_n_ret   = '0;
    w_chain   = 1'b1;
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      w_ret_idx[k] = r_tail + IB'(k);
      if (w_chain && (CW'(k) < w_ret_lim) && r_committed[w_ret_idx[k]]) begin
        w_ret_ok[k] = 1'b1;
        w_n_ret     = w_n_ret + CW'(1);
      end else begin
        w_chain = 1'b0;
      end
    end

    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:      if (w_flush_acc && (w_flush_n != '0)) w_state_nxt = ST_ROLLBACK;
      ST_ROLLBACK: if (r_rb_left == CW'(1))              w_state_nxt = ST_RUN;
      default:     w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_RUN;
      r_head           <= '0;
      r_tail           <= '0;
      r_count          <= '0;
      r_rb_left        <= '0;
      r_committed      <= '0;
      r_retire_valid   <= '0;
      r_retire_inst_id <= '0;
      r_freed_valid    <= '0;
      r_freed_prns     <= '0;
      r_rb_valid       <= 1'b0;
      r_rb_done        <= 1'b0;
      r_rb_map_valid   <= '0;
      r_rb_map_prn     <= '0;
      r_rb_map_arn     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_rb)        r_head <= w_rb_idx;
      else if (w_disp) r_head <= r_head + IB'(1);
      r_tail  <= r_tail + IB'(w_n_ret);
      r_count <= r_count + CW'(w_disp) - w_n_ret - CW'(w_rb);

      if (w_flush_acc) r_rb_left <= w_flush_n;
      else if (w_rb)   r_rb_left <= r_rb_left - CW'(1);

      for (int f = 0; f < FU_COUNT; f++)
        if (bus.fu_out_inst_valid[f] && w_fu_occ[f])
          r_committed[bus.fu_out_inst_ids[f]] <= 1'b1;
      if (w_disp) r_committed[r_head] <= 1'b0;

      for (int k = 0; k < RETIRE_WIDTH; k++) begin
        r_retire_valid[k]   <= w_ret_ok[k];
        r_retire_inst_id[k] <= w_ret_ok[k] ? w_ret_idx[k] : '0;
        r_freed_valid[k]    <= w_ret_ok[k] ? r_map_valid[w_ret_idx[k]] : '0;
        r_freed_prns[k]     <= w_ret_ok[k] ? r_map_prn[w_ret_idx[k]] : '0;
      end

      r_rb_valid     <= w_rb;
      r_rb_map_valid <= w_rb ? r_map_valid[w_rb_idx] : '0;
      r_rb_map_prn   <= w_rb ? r_map_prn[w_rb_idx] : '0;
      r_rb_map_arn   <= w_rb ? r_map_arn[w_rb_idx] : '0;
      r_rb_done      <= (w_flush_acc && (w_flush_n == '0)) || (w_rb && (r_rb_left == CW'(1)));
    end
  end

  always_ff @(posedge clk) begin
    if (w_disp) begin
      r_pc[r_head]        <= bus.pc;
      r_map_valid[r_head] <= bus.mapping_inputs_valid;
      r_map_prn[r_head]   <= bus.mapping_inputs_prn;
      r_map_arn[r_head]   <= bus.mapping_inputs_arn;
    end
  end

  assign bus.inst_ready             = w_ready;
  assign bus.new_inst_id            = r_head;
  assign bus.empty                  = (r_count == '0);
  assign bus.retire_valid           = r_retire_valid;
  assign bus.retire_inst_id         = r_retire_inst_id;
  assign bus.freed_prns_valid       = r_freed_valid;
  assign bus.freed_prns             = r_freed_prns;
  assign bus.rollback_valid         = r_rb_valid;
  assign bus.rollback_mapping_valid = r_rb_map_valid;
  assign bus.rollback_mapping_prn   = r_rb_map_prn;
  assign bus.rollback_mapping_arn   = r_rb_map_arn;
  assign bus.rollback_done          = r_rb_done;
endmodule

// File: tb/tb_rob_mw.sv
// Bench for rob_mw: queue-based reference model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_rob_mw;
  localparam int IB = 6, PB = 6, MO = 3, FC = 4, RW = 2;
  localparam int DEPTH = 1 << IB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rob_mw_if #(.INST_ID_BITS(IB), .PRN_BITS(PB), .MAX_OPERANDS(MO),
              .FU_COUNT(FC), .RETIRE_WIDTH(RW)) rif ();

  rob_mw #(.INST_ID_BITS(IB), .PRN_BITS(PB), .MAX_OPERANDS(MO),
           .FU_COUNT(FC), .RETIRE_WIDTH(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (rif)
  );

  typedef struct {
    int                   id;
    bit                   done;
    logic [MO-1:0]        mv;
    logic [MO-1:0][PB-1:0] mp;
    logic [MO-1:0][5:0]   ma;
  } ent_t;

  ent_t q[$];    // live entries, oldest first
  ent_t rbq[$];  // squashed entries still to replay, youngest first
  int   m_tail;

  logic [RW-1:0]                 e_rv;
  logic [RW-1:0][IB-1:0]         e_rid;
  logic [RW-1:0][MO-1:0]         e_fv;
  logic [RW-1:0][MO-1:0][PB-1:0] e_fp;
  logic                          e_bv, e_done;
  logic [MO-1:0]                 e_bmv;
  logic [MO-1:0][PB-1:0]         e_bmp;
  logic [MO-1:0][5:0]            e_bma;

  int n_chk = 0, n_pass = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic clear_exp();
    e_rv = '0; e_rid = '0; e_fv = '0; e_fp = '0;
    e_bv = 1'b0; e_done = 1'b0; e_bmv = '0; e_bmp = '0; e_bma = '0;
  endtask

  task automatic model_step();
    int c, hd, nret, p, n;
    bit rb_act, rdy, chain;
    ent_t e;
    c      = q.size() + rbq.size();
    hd     = (m_tail + c) % DEPTH;
    rb_act = (rbq.size() != 0);
    rdy    = !rb_act && (c < DEPTH) && !rif.flush_valid;
    clear_exp();
    if (rb_act) begin
      e = rbq.pop_front();
      e_bv = 1'b1; e_bmv = e.mv; e_bmp = e.mp; e_bma = e.ma;
      e_done = (rbq.size() == 0);
    end else if (rif.flush_valid) begin
      p = -1;
      foreach (q[i]) if (q[i].id == int'(rif.flush_inst_id)) p = i;
      if (p >= 0) begin
        n = q.size() - 1 - p;
        for (int i = 0; i < n; i++) rbq.push_back(q.pop_back());
        if (n == 0) e_done = 1'b1;
      end
    end
    nret = 0; chain = 1'b1;
    for (int k = 0; k < RW; k++) begin
      if (chain && k < q.size() && q[k].done) begin
        e_rv[k] = 1'b1; e_rid[k] = IB'(q[k].id); e_fv[k] = q[k].mv; e_fp[k] = q[k].mp;
        nret++;
      end else chain = 1'b0;
    end
    for (int f = 0; f < FC; f++)
      if (rif.fu_out_inst_valid[f])
        foreach (q[i]) if (q[i].id == int'(rif.fu_out_inst_ids[f])) q[i].done = 1'b1;
    if (rif.inst_valid && rdy) begin
      e.id = hd; e.done = 1'b0;
      e.mv = rif.mapping_inputs_valid; e.mp = rif.mapping_inputs_prn; e.ma = rif.mapping_inputs_arn;
      q.push_back(e);
    end
    repeat (nret) void'(q.pop_front());
    m_tail = (m_tail + nret) % DEPTH;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete(); rbq.delete(); m_tail = 0; clear_exp();
    end else model_step();
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      int c;
      c = q.size() + rbq.size();
      chk("inst_ready", rif.inst_ready, (rbq.size() == 0) && (c < DEPTH) && !rif.flush_valid);
      chk("new_inst_id", rif.new_inst_id, (m_tail + c) % DEPTH);
      chk("empty", rif.empty, c == 0);
      chk("retire_valid", rif.retire_valid, e_rv);
      chk("retire_inst_id", rif.retire_inst_id, e_rid);
      chk("freed_prns_valid", rif.freed_prns_valid, e_fv);
      chk("freed_prns", rif.freed_prns, e_fp);
      chk("rollback_valid", rif.rollback_valid, e_bv);
      chk("rollback_map_valid", rif.rollback_mapping_valid, e_bmv);
      chk("rollback_map_prn", rif.rollback_mapping_prn, e_bmp);
      chk("rollback_map_arn", rif.rollback_mapping_arn, e_bma);
      chk("rollback_done", rif.rollback_done, e_done);
    end
  end

  task automatic idle();
    rif.inst_valid = 1'b0; rif.pc = '0;
    rif.mapping_inputs_valid = '0; rif.mapping_inputs_prn = '0; rif.mapping_inputs_arn = '0;
    rif.fu_out_inst_valid = '0; rif.fu_out_inst_ids = '0;
    rif.flush_valid = 1'b0; rif.flush_inst_id = '0;
  endtask

  // tag t: prn[j] = (t+10j)%64, arn[j] = (t+j+1)%32, odd tags drop mapping 2
  task automatic drive_disp(input int t);
    rif.inst_valid = 1'b1;
    rif.pc = 64'h1000 + 64'(t * 4);
    rif.mapping_inputs_valid = (t % 2 == 1) ? 3'b011 : 3'b111;
    for (int j = 0; j < MO; j++) begin
      rif.mapping_inputs_prn[j] = PB'((t + 10 * j) % 64);
      rif.mapping_inputs_arn[j] = 6'((t + j + 1) % 32);
    end
  endtask

  task automatic complete(input int port, input int id);
    rif.fu_out_inst_valid[port] = 1'b1;
    rif.fu_out_inst_ids[port] = IB'(id);
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); rst_n = 1'b0; nxt(); nxt(); rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; cmp_en = 1'b1;
    #1;
    chk("rst_empty", rif.empty, 1);
    chk("rst_new_id", rif.new_inst_id, 0);
    chk("rst_ready", rif.inst_ready, 1);
    chk("rst_retire", rif.retire_valid, 0);

    // complete 3,1,0,2 together -> retire 0,1 then 2,3
    for (int i = 0; i < 4; i++) begin idle(); drive_disp(i); nxt(); end
    idle(); complete(0, 3); complete(1, 1); complete(2, 0); complete(3, 2);
    nxt(); idle(); nxt();
    chk("r01_valid", rif.retire_valid, 2'b11);
    chk("r01_id0", rif.retire_inst_id[0], 0);
    chk("r01_id1", rif.retire_inst_id[1], 1);
    chk("r01_prn01", rif.freed_prns[0][1], 10);
    chk("r01_prn12", rif.freed_prns[1][2], 21);
    chk("r01_fv1", rif.freed_prns_valid[1], 3'b011);
    nxt();
    chk("r23_id0", rif.retire_inst_id[0], 2);
    chk("r23_id1", rif.retire_inst_id[1], 3);
    chk("r23_prn00", rif.freed_prns[0][0], 2);
    chk("r23_fv0", rif.freed_prns_valid[0], 3'b111);
    chk("r23_empty", rif.empty, 1);

    // 10 outstanding, flush at 4 -> replay 9..5; retire 0,1 meanwhile
    do_reset();
    for (int i = 0; i < 10; i++) begin idle(); drive_disp(i); nxt(); end
    idle(); rif.flush_valid = 1'b1; rif.flush_inst_id = 6'd4;
    #1 chk("flush_ready_low", rif.inst_ready, 0);
    nxt(); idle();
    chk("flush_no_rb_yet", rif.rollback_valid, 0);
    complete(0, 0); complete(1, 1);
    for (int r = 0; r < 5; r++) begin
      nxt(); idle(); #1;
      chk("rb_valid", rif.rollback_valid, 1);
      chk("rb_prn0", rif.rollback_mapping_prn[0], 9 - r);
      chk("rb_arn2", rif.rollback_mapping_arn[2], (9 - r + 3) % 32);
      chk("rb_done", rif.rollback_done, r == 4);
      chk("rb_ready", rif.inst_ready, r == 4);
    end
    chk("post_rb_new_id", rif.new_inst_id, 5);

    // flush on the youngest entry (4)
    nxt(); idle(); rif.flush_valid = 1'b1; rif.flush_inst_id = 6'd4;
    #1 chk("young_ready_low", rif.inst_ready, 0);
    nxt(); idle(); #1;
    chk("young_done", rif.rollback_done, 1);
    chk("young_no_rb", rif.rollback_valid, 0);
    chk("young_ready", rif.inst_ready, 1);
    nxt();
    chk("young_done_clear", rif.rollback_done, 0);

    // fill all 64 slots
    do_reset();
    for (int i = 0; i < 64; i++) begin
      idle(); drive_disp(i); #1;
      chk("fill_id", rif.new_inst_id, i);
      chk("fill_ready", rif.inst_ready, 1);
      nxt();
    end
    idle(); #1;
    chk("full_ready", rif.inst_ready, 0);
    chk("full_empty", rif.empty, 0);
    complete(0, 0);
    nxt(); idle(); #1;
    chk("full_ret_ready", rif.inst_ready, 0);
    nxt();
    chk("full_ret_valid", rif.retire_valid, 2'b01);
    chk("full_ret_id", rif.retire_inst_id[0], 0);
    chk("ready_after_ret", rif.inst_ready, 1);

    // wrap: advance to 62, then IDs 62,63,0,1
    do_reset();
    for (int i = 0; i < 62; i++) begin
      idle(); drive_disp(i);
      if (i > 0) complete(0, i - 1);
      nxt();
    end
    idle(); complete(0, 61); complete(1, 10);
    nxt(); idle(); repeat (3) nxt();
    chk("wrap_start_id", rif.new_inst_id, 62);
    chk("wrap_start_empty", rif.empty, 1);
    for (int i = 0; i < 4; i++) begin idle(); drive_disp(62 + i); nxt(); end
    idle(); complete(0, 1); complete(1, 0); complete(2, 63); complete(3, 62);
    nxt(); idle(); nxt();
    chk("wrap_id0", rif.retire_inst_id[0], 62);
    chk("wrap_id1", rif.retire_inst_id[1], 63);
    chk("wrap_prn01", rif.freed_prns[0][1], 8);
    nxt();
    chk("wrap_id2", rif.retire_inst_id[0], 0);
    chk("wrap_id3", rif.retire_inst_id[1], 1);
    chk("wrap_empty", rif.empty, 1);

    // reset during rollback
    do_reset();
    for (int i = 0; i < 6; i++) begin idle(); drive_disp(i); nxt(); end
    idle(); rif.flush_valid = 1'b1; rif.flush_inst_id = 6'd1;
    nxt(); idle(); nxt();
    chk("mid_rb_valid", rif.rollback_valid, 1);
    rst_n = 1'b0; #1;
    chk("rst_rb_valid", rif.rollback_valid, 0);
    chk("rst_rb_map", rif.rollback_mapping_valid, 0);
    chk("rst_retire_valid", rif.retire_valid, 0);
    nxt(); rst_n = 1'b1; #1;
    chk("rel_empty", rif.empty, 1);
    chk("rel_new_id", rif.new_inst_id, 0);
    chk("rel_ready", rif.inst_ready, 1);
    drive_disp(0); nxt(); idle(); #1;
    chk("rel_next_id", rif.new_inst_id, 1);
    nxt(); nxt();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rob_mw.md
# rob_mw

Parametrised reorder buffer with a full-depth circular queue. It accepts one renamed instruction per cycle and retires up to RETIRE_WIDTH in-order committed instructions per cycle. On a branch or exception flush it squashes all younger entries and replays their overwritten mappings to the renamer, one per cycle, so the renamer can restore its map table. It sits between the renamer (dispatch, freed PRNs, rollback), the functional units (completion) and the LSU (store retirement).

## Interface
- INST_ID_BITS, 6, log2 of depth; DEPTH = 1<<INST_ID_BITS
- PRN_BITS, 6, physical register number width
- MAX_OPERANDS, 3, mapping slots per entry
- FU_COUNT, 4, completion ports
- RETIRE_WIDTH, 2, max retirements per cycle (1..DEPTH)
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- inst_valid  in  1  dispatch request
- inst_ready  out  1  dispatch accept, combinational
- pc  in  64  instruction PC
- mapping_inputs_valid[MAX_OPERANDS]  in  1  overwritten-mapping valid
- mapping_inputs_prn[MAX_OPERANDS]  in  PRN_BITS  overwritten PRN
- mapping_inputs_arn[MAX_OPERANDS]  in  6  architectural register
- new_inst_id  out  INST_ID_BITS  ID of the slot being dispatched into, combinational (= head)
- fu_out_inst_valid[FU_COUNT]  in  1  completion valid
- fu_out_inst_ids[FU_COUNT]  in  INST_ID_BITS  completed ID
- flush_valid  in  1  flush request
- flush_inst_id  in  INST_ID_BITS  flushing instruction; this instruction is kept, all younger ones are squashed
- retire_valid[RETIRE_WIDTH]  out  1  lane retired, registered; lane 0 is the oldest
- retire_inst_id[RETIRE_WIDTH]  out  INST_ID_BITS  retired ID
- freed_prns_valid[RETIRE_WIDTH][MAX_OPERANDS]  out  1  PRN freed
- freed_prns[RETIRE_WIDTH][MAX_OPERANDS]  out  PRN_BITS  freed PRN
- rollback_valid  out  1  one squashed entry being replayed, registered
- rollback_mapping_valid/prn/arn[MAX_OPERANDS]  out  1/PRN_BITS/6  that entry's overwritten mappings
- rollback_done  out  1  one-cycle pulse when the flush is fully handled
- empty  out  1  count == 0

## Operation
- State per entry: ISSUED or COMMITTED, pc, and the mappings. Pointers: head (next allocation), tail (oldest). count has INST_ID_BITS+1 bits, so all DEPTH slots are usable.
- FSM RUN / ROLLBACK.
  - inst_ready = RUN && count < DEPTH && !flush_valid.
- Dispatch (inst_valid && inst_ready):
  - Write the entry at head with state ISSUED.
  - head+1, wrapping mod DEPTH.
- Completion: each valid FU port sets its entry to COMMITTED.
  - Multiple ports may hit distinct IDs in the same cycle.
  - IDs not currently occupied are ignored.
- Retire, in both RUN and ROLLBACK:
  - Lane k retires entry tail+k if k < count and entries tail..tail+k are all COMMITTED. Lanes retire strictly in order, with no gaps.
  - Retired lanes drive retire_valid/retire_inst_id and the freed PRNs from the stored mapping_valid/prn.
  - tail and count advance by the number retired.
- Flush, accepted only in RUN when flush_inst_id is occupied (ignored otherwise):
  - n = number of entries younger than flush_inst_id.
  - n == 0: stay in RUN; rollback_done pulses next cycle.
  - n > 0: enter ROLLBACK. Each cycle, head decrements (wrapping), the entry at the new head is replayed on the rollback outputs, and count decrements. Replay is youngest first.
  - The last replay cycle also asserts rollback_done, then the FSM returns to RUN.
- Count per cycle = count + dispatched − retired − rolled back. It never exceeds DEPTH and never underflows.

## Timing
- rst_n low, asynchronously: head=tail=count=0, FSM=RUN, every registered output 0, all entries ISSUED. A reset mid-ROLLBACK abandons the replay.
- Dispatch → earliest completion: same-cycle completion of new_inst_id is not allowed; the earliest completion is the next cycle.
- Completion at edge N → earliest retirement outputs valid after edge N+1.
- Registered outputs are valid for exactly one cycle per event.
- Flush sampled at edge N:
  - First rollback_valid after edge N+1.
  - inst_ready is low from the cycle flush_valid is high until the cycle after rollback_done.
  - Retirement continues throughout.
- Full (count == DEPTH): inst_ready is low even if retirement happens in the same cycle; ready rises the cycle after.
- Pointer arithmetic is mod DEPTH. Occupancy tests use (id − tail) mod DEPTH < count.

## Test plan
- Dispatch 64 instructions with no completions → inst_ready low after the 64th, new_inst_id 0..63, empty=0.
- Complete IDs 3,1,0,2 on separate ports in one cycle → next cycle lanes retire 0,1; following cycle retire 2,3 with the correct freed PRNs.
- 10 outstanding, flush_inst_id=4 → 5 rollback cycles replaying IDs 9,8,7,6,5 with their stored mappings, rollback_done on the 5th; the next dispatch gets ID 5.
- Flush on the youngest entry → no rollback_valid; rollback_done one cycle later; inst_ready low for that cycle only.
- Wrap: tail=62, head=62, dispatch 4, commit all → IDs 62,63,0,1 retire in order; count returns to 0.
- Assert rst_n low during a rollback → all outputs 0 immediately; empty=1 after release; dispatch restarts at ID 0.
